// File: rtl/frog_input_sequencer.sv
// Turns the four debounced player switches into registered one-cycle move pulses,
// a facing-direction code and a chord-triggered game-start pulse.
module frog_input_sequencer #(
  parameter int unsigned C_REPEAT_DELAY  = 2_500_000,
  parameter int unsigned C_REPEAT_PERIOD = 1_250_000,
  parameter int unsigned C_CHORD_HOLD    = 5_000_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  input  logic       i_Game_Active,
  output logic       o_Move_Up,
  output logic       o_Move_Lt,
  output logic       o_Move_Rt,
  output logic       o_Move_Dn,
  output logic [1:0] o_Frog_Direction,
  output logic       o_Start
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT,
    S_CHORD,
    S_WAIT_REL
  } state_t;

  localparam logic [23:0] C_DELAY_LAST  = 24'(C_REPEAT_DELAY - 1);
  localparam logic [23:0] C_PERIOD_LAST = 24'(C_REPEAT_PERIOD - 1);
  localparam logic [23:0] C_CHORD_LAST  = 24'(C_CHORD_HOLD - 1);

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  dir_q, dir_d;
  logic [1:0]  prio_dir;
  logic [3:0]  sw;
  logic [3:0]  move_q, move_d;
  logic [1:0]  face_d;
  logic        start_d;
  logic        pulse;
  logic        any_sw, all_sw, latched_sw;

  // Bit index equals the direction code: 0=Up, 1=Left, 2=Right, 3=Down.
  assign sw         = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
  assign any_sw     = |sw;
  assign all_sw     = &sw;
  assign latched_sw = sw[dir_q];

  always_comb begin
    prio_dir = 2'd3;
    if (sw[0])      prio_dir = 2'd0;
    else if (sw[1]) prio_dir = 2'd1;
    else if (sw[2]) prio_dir = 2'd2;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 24'd1;
    dir_d   = dir_q;
    pulse   = 1'b0;
    start_d = 1'b0;
    move_d  = '0;
    face_d  = o_Frog_Direction;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (all_sw) begin
          state_d = S_CHORD;
        end else if (any_sw) begin
          dir_d   = prio_dir;
          pulse   = 1'b1;
          state_d = S_DELAY;
        end
      end

      S_DELAY, S_REPEAT: begin
        // Chord detection outranks the release checks.
        if (all_sw) begin
          cnt_d   = '0;
          state_d = S_CHORD;
        end else if (!latched_sw) begin
          cnt_d   = '0;
          state_d = any_sw ? S_WAIT_REL : S_IDLE;
        end else if (state_q == S_DELAY && cnt_q == C_DELAY_LAST) begin
          cnt_d   = '0;
          pulse   = 1'b1;
          state_d = S_REPEAT;
        end else if (state_q == S_REPEAT && cnt_q == C_PERIOD_LAST) begin
          cnt_d = '0;
          pulse = 1'b1;
        end
      end

      S_CHORD: begin
        if (!all_sw) begin
          cnt_d   = '0;
          state_d = S_WAIT_REL;
        end else if (cnt_q == C_CHORD_LAST) begin
          cnt_d   = '0;
          start_d = !i_Game_Active;
          state_d = S_WAIT_REL;
        end
      end

      S_WAIT_REL: begin
        cnt_d = '0;
        if (!any_sw) state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    if (pulse && i_Game_Active) begin
      move_d[dir_d] = 1'b1;
      face_d        = dir_d;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      dir_q            <= '0;
      move_q           <= '0;
      o_Frog_Direction <= '0;
      o_Start          <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      dir_q            <= dir_d;
      move_q           <= move_d;
      o_Frog_Direction <= face_d;
      o_Start          <= start_d;
    end
  end

  assign o_Move_Up = move_q[0];
  assign o_Move_Lt = move_q[1];
  assign o_Move_Rt = move_q[2];
  assign o_Move_Dn = move_q[3];

endmodule

// File: tb/tb_frog_input_sequencer.sv
// Directed bench for frog_input_sequencer with short timing parameters (8/4/5).
module tb_frog_input_sequencer;

  logic       clk;
  logic       rst_n;
  logic       sw1, sw2, sw3, sw4;
  logic       active;
  logic       mv_up, mv_lt, mv_rt, mv_dn;
  logic [1:0] face;
  logic       start;

  int checks   = 0;
  int failures = 0;

  frog_input_sequencer #(
    .C_REPEAT_DELAY (8),
    .C_REPEAT_PERIOD(4),
    .C_CHORD_HOLD   (5)
  ) dut (
    .i_Clk           (clk),
    .i_Rst_L         (rst_n),
    .i_Switch_1      (sw1),
    .i_Switch_2      (sw2),
    .i_Switch_3      (sw3),
    .i_Switch_4      (sw4),
    .i_Game_Active   (active),
    .o_Move_Up       (mv_up),
    .o_Move_Lt       (mv_lt),
    .o_Move_Rt       (mv_rt),
    .o_Move_Dn       (mv_dn),
    .o_Frog_Direction(face),
    .o_Start         (start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Moves are packed {Dn,Rt,Lt,Up}.
  task automatic chk_outs(input string tag, input logic [3:0] exp_mv,
                          input logic [1:0] exp_face, input logic exp_start);
    chk({tag, ".move"},  32'({mv_dn, mv_rt, mv_lt, mv_up}), 32'(exp_mv));
    chk({tag, ".dir"},   32'(face), 32'(exp_face));
    chk({tag, ".start"}, 32'(start), 32'(exp_start));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] em;
    logic [1:0] ef;
    rst_n  = 1'b0;
    sw1    = 1'b0; sw2 = 1'b0; sw3 = 1'b0; sw4 = 1'b0;
    active = 1'b0;
    cyc(); cyc();
    chk_outs("reset_init", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    cyc(); cyc();
    chk_outs("idle_after_reset", 4'b0000, 2'd0, 1'b0);

    // Single tap on Left.
    active = 1'b1;
    sw2    = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk_outs($sformatf("tap_lt_c%0d", i), (i == 1) ? 4'b0010 : 4'b0000, 2'd1, 1'b0);
      if (i == 3) sw2 = 1'b0;
    end

    // Hold Down for 30 cycles.
    sw4 = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      cyc();
      em = (i == 1 || (i >= 9 && i <= 29 && (i - 9) % 4 == 0)) ? 4'b1000 : 4'b0000;
      chk_outs($sformatf("hold_dn_c%0d", i), em, 2'd3, 1'b0);
      if (i == 30) sw4 = 1'b0;
    end

    // Up and Right together, then drop Up while Right stays.
    sw1 = 1'b1;
    sw3 = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      cyc();
      em = (i == 1) ? 4'b0001 : (i == 13) ? 4'b0100 : 4'b0000;
      ef = (i >= 13) ? 2'd2 : 2'd0;
      chk_outs($sformatf("prio_c%0d", i), em, ef, 1'b0);
      if (i == 2)  sw1 = 1'b0;
      if (i == 10) sw3 = 1'b0;
      if (i == 12) sw3 = 1'b1;
      if (i == 13) sw3 = 1'b0;
    end
    cyc(); cyc();

    // Hold Right into repeat, then reset asynchronously during a pulse.
    sw3 = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      chk_outs($sformatf("rst_hold_c%0d", i), (i == 1 || i == 9) ? 4'b0100 : 4'b0000, 2'd2, 1'b0);
    end
    #1 rst_n = 1'b0;
    #1 chk_outs("rst_async", 4'b0000, 2'd0, 1'b0);
    cyc();
    chk_outs("rst_held", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    cyc();
    chk_outs("rst_rel_c1", 4'b0100, 2'd2, 1'b0);
    cyc();
    chk_outs("rst_rel_c2", 4'b0000, 2'd2, 1'b0);
    sw3 = 1'b0;
    cyc(); cyc();

    // Chord start with the game inactive.
    active = 1'b0;
    sw1 = 1'b1; sw2 = 1'b1; sw3 = 1'b1; sw4 = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      cyc();
      chk_outs($sformatf("chord_c%0d", i), 4'b0000, 2'd2, (i == 6));
      if (i == 10) begin
        sw1 = 1'b0; sw2 = 1'b0; sw3 = 1'b0; sw4 = 1'b0;
      end
    end

    // Chord broken after 3 cycles.
    sw1 = 1'b1; sw2 = 1'b1; sw3 = 1'b1; sw4 = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      cyc();
      chk_outs($sformatf("chord_abort_c%0d", i), 4'b0000, 2'd2, 1'b0);
      if (i == 3) sw2 = 1'b0;
      if (i == 10) begin
        sw1 = 1'b0; sw3 = 1'b0; sw4 = 1'b0;
      end
    end

    // Up held while inactive; game becomes active at cycle 10.
    sw1 = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      cyc();
      em = (i == 13 || i == 17) ? 4'b0001 : 4'b0000;
      ef = (i >= 13) ? 2'd0 : 2'd2;
      chk_outs($sformatf("gate_up_c%0d", i), em, ef, 1'b0);
      if (i == 10) active = 1'b1;
      if (i == 20) sw1 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
